cond_unit_it: RTL and testbench

- Parametrised successor of the single-cycle conditional logic block in the ControlUnit.
- Holds the architectural NZCV flags and evaluates condition codes against them.
- Gates pc_src, reg_write and mem_write, and adds Thumb-style IT-block predication: one IT instruction makes up to MAX_BLOCK following instructions conditional on a shared base condition, each slot marked then or else.
- Adds stall, flush and error reporting for use with a pipelined datapath.

---
 rtl/cond_unit_it_pkg.sv | 49 ++++
 rtl/cond_unit_it_if.sv | 43 ++++
 rtl/cond_unit_it_tracker.sv | 121 ++++++++++++
 rtl/cond_unit_it.sv | 85 ++++++++
 tb/tb_cond_unit_it.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cond_unit_it_pkg.sv
// Shared definitions for the conditional-execution unit: condition codes,
// flag bit positions, IT tracker states and the condition evaluator.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    typedef enum logic {
        IT_IDLE   = 1'b0,
        IT_ACTIVE = 1'b1
    } it_state_e;

    // Evaluates a condition code against a flag vector; NV never passes.
    function automatic logic cond_check(cond_e c, logic [3:0] f);
        logic res;
        res = 1'b0;
        case (c)
            EQ: res = f[Z];
            NE: res = ~f[Z];
            CS: res = f[C];
            CC: res = ~f[C];
            MI: res = f[N];
            PL: res = ~f[N];
            VS: res = f[V];
            VC: res = ~f[V];
            HI: res = f[C] & ~f[Z];
            LS: res = ~f[C] | f[Z];
            GE: res = (f[N] == f[V]);
            LT: res = (f[N] != f[V]);
            GT: res = ~f[Z] & (f[N] == f[V]);
            LE: res = f[Z] | (f[N] != f[V]);
            AL: res = 1'b1;
            NV: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cond_unit_it_if.sv
// Decoder/datapath-facing bundle of the conditional-execution unit.
interface cond_unit_it_if #(
    parameter int MAX_BLOCK = 4
);
    localparam int LEN_W = $clog2(MAX_BLOCK + 1);

    logic                 instr_valid;
    logic                 stall;
    logic                 flush;
    logic [3:0]           cond;
    logic                 it_start;
    logic [3:0]           it_cond;
    logic [LEN_W-1:0]     it_len;
    logic [MAX_BLOCK-1:0] it_te;
    logic [3:0]           alu_flags;
    logic [1:0]           flag_w;
    logic                 pcs;
    logic                 reg_w;
    logic                 mem_w;

    logic                 pc_src;
    logic                 reg_write;
    logic                 mem_write;
    logic                 cond_ex;
    logic [3:0]           flags;
    logic                 it_active;
    logic [LEN_W-1:0]     it_remaining;
    logic                 it_err;

    modport master (
        output instr_valid, stall, flush, cond, it_start, it_cond, it_len, it_te,
               alu_flags, flag_w, pcs, reg_w, mem_w,
        input  pc_src, reg_write, mem_write, cond_ex, flags, it_active,
               it_remaining, it_err
    );

    modport slave (
        input  instr_valid, stall, flush, cond, it_start, it_cond, it_len, it_te,
               alu_flags, flag_w, pcs, reg_w, mem_w,
        output pc_src, reg_write, mem_write, cond_ex, flags, it_active,
               it_remaining, it_err
    );
endinterface

// File: rtl/cond_unit_it_tracker.sv
// IT-block tracker: latches the base condition and then/else mask of an IT
// instruction and walks through its slots, reporting which condition source
// the current instruction must use.
module it_tracker
    import cond_pkg::*;
#(
    parameter int MAX_BLOCK = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 go,
    input  logic                                 flush,
    input  logic                                 it_start,
    input  logic [3:0]                           it_cond,
    input  logic [$clog2(MAX_BLOCK+1)-1:0]       it_len,
    input  logic [MAX_BLOCK-1:0]                 it_te,
    input  logic                                 branch,
    output logic                                 it_active,
    output logic                                 use_else,
    output logic [3:0]                           base_cond,
    output logic [$clog2(MAX_BLOCK+1)-1:0]       it_remaining,
    output logic                                 it_err
);
    localparam int LEN_W = $clog2(MAX_BLOCK + 1);
    localparam int IDX_W = (MAX_BLOCK > 1) ? $clog2(MAX_BLOCK) : 1;

    it_state_e            state_q, state_d;
    logic [3:0]           cond_q, cond_d;
    logic [MAX_BLOCK-1:0] te_q, te_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic                 err_q, err_d;
    logic                 len_ok;

    assign len_ok = (it_len != '0) && (it_len <= LEN_W'(MAX_BLOCK));

    // State register and latched block context.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so ordering inside this block does not matter.
        if (rst) begin
            // NOTE: the latched condition and mask are reset too; they are a
            // handful of flops, not a memory, and keeping them defined avoids
            // X on eff_cond selection paths.
            state_q <= IT_IDLE;
            cond_q  <= '0;
            te_q    <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            te_q    <= te_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: load on IT, consume a slot per issued instruction,
    // abort on branch, nested IT or flush.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cond_d  = cond_q;
        te_d    = te_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        err_d   = 1'b0;

        case (state_q)
            IT_IDLE: begin
                if (go && it_start) begin
                    if (len_ok) begin
                        state_d = IT_ACTIVE;
                        cond_d  = it_cond;
                        te_d    = it_te | MAX_BLOCK'(1);
                        idx_d   = '0;
                        rem_d   = it_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            IT_ACTIVE: begin
                if (go) begin
                    if (it_start) begin
                        err_d   = 1'b1;
                        state_d = IT_IDLE;
                        rem_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        rem_d = rem_q - 1'b1;
                        if (rem_q == LEN_W'(1) || branch) begin
                            state_d = IT_IDLE;
                            rem_d   = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = IT_IDLE;
                rem_d   = '0;
            end
        endcase

        if (flush) begin
            state_d = IT_IDLE;
            rem_d   = '0;
        end
    end

    assign it_active    = (state_q == IT_ACTIVE);
    assign use_else     = ~te_q[idx_q];
    assign base_cond    = cond_q;
    assign it_remaining = rem_q;
    assign it_err       = err_q;

endmodule

// File: rtl/cond_unit_it.sv
// Conditional-execution unit: holds NZCV, evaluates the effective condition
// (plain or IT-predicated) and gates the decoder's write requests.
module cond_unit_it
    import cond_pkg::*;
#(
    parameter int MAX_BLOCK = 4
) (
    input logic           clk,
    input logic           rst,
    cond_unit_it_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_BLOCK + 1);

    logic             go;
    logic             it_active;
    logic             use_else;
    logic [3:0]       base_cond;
    logic [3:0]       eff_cond;
    logic             cond_ex;
    logic             pc_src;
    logic [3:0]       flags_q;
    logic [LEN_W-1:0] it_remaining;
    logic             it_err;

    assign go = bus.instr_valid & ~bus.stall & ~rst;

    it_tracker #(
        .MAX_BLOCK(MAX_BLOCK)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .flush       (bus.flush),
        .it_start    (bus.it_start),
        .it_cond     (bus.it_cond),
        .it_len      (bus.it_len),
        .it_te       (bus.it_te),
        .branch      (pc_src),
        .it_active   (it_active),
        .use_else    (use_else),
        .base_cond   (base_cond),
        .it_remaining(it_remaining),
        .it_err      (it_err)
    );

    // Pick the condition source: instruction field outside a block, base
    // condition (or its inverse for else slots) inside one.
    always_comb begin
        eff_cond = bus.cond;
        if (it_active) begin
            eff_cond = use_else ? {base_cond[3:1], ~base_cond[0]} : base_cond;
        end
    end

    // IT instructions themselves never pass, so they cannot write anything.
    assign cond_ex = bus.instr_valid & ~rst & ~bus.it_start &
                     cond_check(cond_e'(eff_cond), flags_q);
    assign pc_src  = go & cond_ex & bus.pcs;

    // Architectural flags: N,Z and C,V update independently on a passing issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (go && cond_ex) begin
            if (bus.flag_w[1]) begin
                flags_q[N] <= bus.alu_flags[N];
                flags_q[Z] <= bus.alu_flags[Z];
            end
            if (bus.flag_w[0]) begin
                flags_q[C] <= bus.alu_flags[C];
                flags_q[V] <= bus.alu_flags[V];
            end
        end
    end

    assign bus.pc_src       = pc_src;
    assign bus.reg_write    = go & cond_ex & bus.reg_w;
    assign bus.mem_write    = go & cond_ex & bus.mem_w;
    assign bus.cond_ex      = cond_ex;
    assign bus.flags        = flags_q;
    assign bus.it_active    = it_active;
    assign bus.it_remaining = it_remaining;
    assign bus.it_err       = it_err;

endmodule

// File: tb/tb_cond_unit_it.sv
// Bench for cond_unit_it: a table of per-cycle {inputs, expected outputs}
// records plus hand-written reset sequences, checked through a queue.
module tb_cond_unit_it;
    import cond_pkg::*;

    localparam int MB = 4;
    localparam int LW = $clog2(MB + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cond_unit_it_if #(.MAX_BLOCK(MB)) bus ();

    cond_unit_it #(.MAX_BLOCK(MB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic          rst;
        logic          valid;
        logic          stall;
        logic          flush;
        logic [3:0]    cond;
        logic          its;
        logic [3:0]    itc;
        logic [LW-1:0] itl;
        logic [MB-1:0] itte;
        logic [3:0]    alu;
        logic [1:0]    fw;
        logic          pcs;
        logic          rw;
        logic          mw;
    } in_t;

    typedef struct packed {
        logic          pc;
        logic          rw;
        logic          mw;
        logic          cx;
        logic [3:0]    fl;
        logic          act;
        logic [LW-1:0] rem;
        logic          err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic in_t nop();
        in_t t;
        t = '0;
        return t;
    endfunction

    function automatic in_t ins(logic [3:0] c, logic [1:0] fw, logic [3:0] alu,
                                logic pcs, logic rw, logic mw);
        in_t t;
        t       = '0;
        t.valid = 1'b1;
        t.cond  = c;
        t.fw    = fw;
        t.alu   = alu;
        t.pcs   = pcs;
        t.rw    = rw;
        t.mw    = mw;
        return t;
    endfunction

    // IT instruction with every write request and flag write raised, so any
    // leak through the suppression shows up.
    function automatic in_t it(logic [3:0] c, int len, logic [MB-1:0] te);
        in_t t;
        t       = ins(AL, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1);
        t.its   = 1'b1;
        t.itc   = c;
        t.itl   = LW'(len);
        t.itte  = te;
        return t;
    endfunction

    function automatic out_t o(logic pc, logic rw, logic mw, logic cx,
                               logic [3:0] fl, logic act, int rem, logic err);
        out_t e;
        e.pc  = pc;
        e.rw  = rw;
        e.mw  = mw;
        e.cx  = cx;
        e.fl  = fl;
        e.act = act;
        e.rem = LW'(rem);
        e.err = err;
        return e;
    endfunction

    task automatic add(input in_t i, input out_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t i);
        rst             = i.rst;
        bus.instr_valid = i.valid;
        bus.stall       = i.stall;
        bus.flush       = i.flush;
        bus.cond        = i.cond;
        bus.it_start    = i.its;
        bus.it_cond     = i.itc;
        bus.it_len      = i.itl;
        bus.it_te       = i.itte;
        bus.alu_flags   = i.alu;
        bus.flag_w      = i.fw;
        bus.pcs         = i.pcs;
        bus.reg_w       = i.rw;
        bus.mem_w       = i.mw;
    endtask

    task automatic check(input string name);
        out_t got;
        out_t want;
        got.pc  = bus.pc_src;
        got.rw  = bus.reg_write;
        got.mw  = bus.mem_write;
        got.cx  = bus.cond_ex;
        got.fl  = bus.flags;
        got.act = bus.it_active;
        got.rem = bus.it_remaining;
        got.err = bus.it_err;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s: got pc/rw/mw/cx=%b%b%b%b flags=%b act=%b rem=%0d err=%b, expected pc/rw/mw/cx=%b%b%b%b flags=%b act=%b rem=%0d err=%b",
                         name, got.pc, got.rw, got.mw, got.cx, got.fl, got.act, got.rem, got.err,
                         want.pc, want.rw, want.mw, want.cx, want.fl, want.act, want.rem, want.err);
            end
        end
    endtask

    // One cycle: drive on the falling edge, compare before the next rising edge.
    task automatic step(input in_t i, input out_t e, input string name);
        @(negedge clk);
        drive(i);
        exp_q.push_back(e);
        #2;
        check(name);
    endtask

    initial begin
        in_t t;

        // Test 1: first instruction after reset, then flag load via AL.
        add(ins(EQ, 2'b11, 4'b0100, 0, 1, 0), o(0,0,0,0, 4'b0000, 0,0,0));
        add(ins(AL, 2'b11, 4'b0100, 0, 1, 0), o(0,1,0,1, 4'b0000, 0,0,0));
        add(nop(),                            o(0,0,0,0, 4'b0100, 0,0,0));
        // Test 2: IT EQ, len 3, then/else/then with Z=1.
        add(it(EQ, 3, 4'b0101),               o(0,0,0,0, 4'b0100, 0,0,0));
        add(ins(NV, 2'b00, 4'h0, 0, 1, 0),    o(0,1,0,1, 4'b0100, 1,3,0));
        add(ins(NV, 2'b00, 4'h0, 0, 1, 0),    o(0,0,0,0, 4'b0100, 1,2,0));
        add(ins(NV, 2'b00, 4'h0, 0, 1, 0),    o(0,1,0,1, 4'b0100, 1,1,0));
        add(nop(),                            o(0,0,0,0, 4'b0100, 0,0,0));
        // Test 3: two stall cycles at slot 1; flag writes must be held off.
        add(it(EQ, 3, 4'b0011),               o(0,0,0,0, 4'b0100, 0,0,0));
        add(ins(NV, 2'b00, 4'h0, 0, 1, 0),    o(0,1,0,1, 4'b0100, 1,3,0));
        t = ins(NV, 2'b11, 4'h0, 0, 1, 0);
        t.stall = 1'b1;
        add(t,                                o(0,0,0,1, 4'b0100, 1,2,0));
        add(t,                                o(0,0,0,1, 4'b0100, 1,2,0));
        add(ins(NV, 2'b00, 4'h0, 0, 1, 0),    o(0,1,0,1, 4'b0100, 1,2,0));
        add(ins(NV, 2'b00, 4'h0, 0, 1, 0),    o(0,0,0,0, 4'b0100, 1,1,0));
        add(nop(),                            o(0,0,0,0, 4'b0100, 0,0,0));
        // Test 4: taken branch in slot 1 ends a 4-slot AL block.
        add(it(AL, 4, 4'b1111),               o(0,0,0,0, 4'b0100, 0,0,0));
        add(ins(NV, 2'b00, 4'h0, 0, 0, 1),    o(0,0,1,1, 4'b0100, 1,4,0));
        add(ins(NV, 2'b00, 4'h0, 1, 0, 0),    o(1,0,0,1, 4'b0100, 1,3,0));
        add(nop(),                            o(0,0,0,0, 4'b0100, 0,0,0));
        // Else slot under AL becomes NV; te bit0 forced to then.
        add(it(AL, 2, 4'b0000),               o(0,0,0,0, 4'b0100, 0,0,0));
        add(ins(NV, 2'b00, 4'h0, 0, 1, 0),    o(0,1,0,1, 4'b0100, 1,2,0));
        add(ins(NV, 2'b00, 4'h0, 0, 1, 0),    o(0,0,0,0, 4'b0100, 1,1,0));
        // Test 5: nested IT aborts; illegal lengths 0 and MAX_BLOCK+1.
        add(it(EQ, 2, 4'b0011),               o(0,0,0,0, 4'b0100, 0,0,0));
        add(it(AL, 1, 4'b1111),               o(0,0,0,0, 4'b0100, 1,2,0));
        add(nop(),                            o(0,0,0,0, 4'b0100, 0,0,1));
        add(it(AL, 0, 4'b1111),               o(0,0,0,0, 4'b0100, 0,0,0));
        add(it(AL, MB + 1, 4'b1111),          o(0,0,0,0, 4'b0100, 0,0,1));
        add(nop(),                            o(0,0,0,0, 4'b0100, 0,0,1));
        add(nop(),                            o(0,0,0,0, 4'b0100, 0,0,0));
        // Test 6: flush together with a passing, flag-writing slot.
        add(it(EQ, 3, 4'b0111),               o(0,0,0,0, 4'b0100, 0,0,0));
        t = ins(NV, 2'b11, 4'b1011, 0, 1, 0);
        t.flush = 1'b1;
        add(t,                                o(0,1,0,1, 4'b0100, 1,3,0));
        add(nop(),                            o(0,0,0,0, 4'b1011, 0,0,0));
        // Condition decode with N=1 Z=0 C=1 V=1.
        add(ins(GE, 2'b00, 4'h0, 0, 0, 0),    o(0,0,0,1, 4'b1011, 0,0,0));
        add(ins(LT, 2'b00, 4'h0, 0, 0, 0),    o(0,0,0,0, 4'b1011, 0,0,0));
        add(ins(HI, 2'b00, 4'h0, 0, 0, 0),    o(0,0,0,1, 4'b1011, 0,0,0));
        add(ins(LS, 2'b00, 4'h0, 0, 0, 0),    o(0,0,0,0, 4'b1011, 0,0,0));
        add(ins(NV, 2'b00, 4'h0, 0, 0, 0),    o(0,0,0,0, 4'b1011, 0,0,0));
        add(ins(MI, 2'b00, 4'h0, 0, 0, 0),    o(0,0,0,1, 4'b1011, 0,0,0));
        add(ins(CC, 2'b00, 4'h0, 0, 0, 0),    o(0,0,0,0, 4'b1011, 0,0,0));
        // Partial flag writes: full, C/V only, N/Z only.
        add(ins(AL, 2'b11, 4'b0001, 0, 0, 0), o(0,0,0,1, 4'b1011, 0,0,0));
        add(ins(AL, 2'b01, 4'b1110, 0, 0, 0), o(0,0,0,1, 4'b0001, 0,0,0));
        add(ins(AL, 2'b10, 4'b0101, 0, 0, 0), o(0,0,0,1, 4'b0010, 0,0,0));
        add(ins(GT, 2'b00, 4'h0, 0, 0, 0),    o(0,0,0,0, 4'b0110, 0,0,0));
        add(ins(LE, 2'b00, 4'h0, 0, 0, 0),    o(0,0,0,1, 4'b0110, 0,0,0));

        // Initial reset: first edge defines the registers, second is checked.
        t       = ins(AL, 2'b11, 4'hF, 1, 1, 1);
        t.rst   = 1'b1;
        drive(t);
        @(posedge clk);
        step(t, o(0,0,0,0, 4'b0000, 0,0,0), "reset");

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].i, tbl[k].e, $sformatf("tbl[%0d]", k));
        end

        // Reset asserted in the middle of a block.
        step(it(EQ, 3, 4'b0111),            o(0,0,0,0, 4'b0110, 0,0,0), "mid_rst_it");
        step(ins(NV, 2'b00, 4'h0, 0, 1, 0), o(0,1,0,1, 4'b0110, 1,3,0), "mid_rst_slot0");
        t     = ins(AL, 2'b11, 4'hF, 1, 1, 1);
        t.rst = 1'b1;
        step(t,                             o(0,0,0,0, 4'b0110, 1,2,0), "mid_rst_assert");
        step(nop(),                         o(0,0,0,0, 4'b0000, 0,0,0), "mid_rst_after");
        step(ins(EQ, 2'b00, 4'h0, 0, 1, 0), o(0,0,0,0, 4'b0000, 0,0,0), "mid_rst_eq");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
